ws2812_pixel_feeder: RTL and testbench

Upstream stage of the WS2812 bit serializer. It holds a frame of NUM_PIXELS RGB pixels in local RAM and applies global brightness scaling. It reorders each pixel to GRB and streams the pixels to the serializer over a valid/ready handshake. After the frame it enforces the chain latch gap. It replaces the free-running "set" pulse with frame-level control so one command refreshes a whole LED chain.

---
 rtl/ws2812_pixel_feeder.sv | 153 +++++++++++++++
 tb/tb_ws2812_pixel_feeder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_pixel_feeder.sv
// WS2812 pixel feeder: frame RAM, brightness scaling, GRB reorder and
// valid/ready streaming to the bit serializer, followed by the latch gap.
//
// Ports:
//   clk, rst_n            system clock, synchronous active-low reset
//   wr_en/wr_addr/wr_rgb  pixel RAM write port, {R,G,B}
//   brightness            global scale, captured on frame_go
//   frame_go              one-cycle request to send a frame
//   pix_color/pix_valid   scaled {G,R,B} pixel towards the serializer
//   pix_ready             serializer accepts the presented pixel
//   ser_busy              serializer still shifting bits
//   busy                  frame in progress (frame_go .. frame_done)
//   frame_done            one-cycle pulse at the end of the latch gap
module ws2812_pixel_feeder #(
    parameter int NUM_PIXELS = 8,
    parameter int CLK_FREQ   = 27000000,
    parameter int LATCH_US   = 60,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_rgb,
    input  logic [7:0]        brightness,
    input  logic              frame_go,
    output logic [23:0]       pix_color,
    output logic              pix_valid,
    input  logic              pix_ready,
    input  logic              ser_busy,
    output logic              busy,
    output logic              frame_done
);

    localparam int LATCH_TICKS = (CLK_FREQ / 1000000) * LATCH_US;
    localparam int IW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int CW = $clog2(LATCH_TICKS + 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_PIXELS - 1);
    localparam logic [CW-1:0] TERM = CW'(LATCH_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PRESENT,
        DRAIN,
        LATCH
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [7:0]    bright_q;

    logic [23:0]   mem [NUM_PIXELS];
    logic [23:0]   rd_data;
    logic          rd_en;
    logic [IW-1:0] rd_addr;
    logic          wr_ok;
    logic [8:0]    gain;
    logic [23:0]   grb_scaled;

    function automatic logic [7:0] scale(input logic [7:0] c,
                                         input logic [8:0] k);
        return 8'(({8'd0, c} * {7'd0, k}) >> 8);
    endfunction

    // Out-of-range addresses would otherwise alias onto low pixels.
    assign wr_ok = wr_en &&
                   ({1'b0, wr_addr} < (ADDR_W + 1)'(NUM_PIXELS));

    // Read is issued on the edge that enters FETCH, so FETCH sees the
    // data one cycle later; a write in that same cycle returns old data.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = idx + IW'(1);
        if (state == IDLE && frame_go) begin
            rd_en   = 1'b1;
            rd_addr = '0;
        end else if (state == PRESENT && pix_ready && idx != LAST) begin
            rd_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_addr[IW-1:0]] <= wr_rgb;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

    assign gain = {1'b0, bright_q} + 9'd1;
    assign grb_scaled = {scale(rd_data[15:8], gain),
                         scale(rd_data[23:16], gain),
                         scale(rd_data[7:0], gain)};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            bright_q   <= '0;
            pix_color  <= '0;
            pix_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (frame_go) begin
                        bright_q <= brightness;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    pix_color <= grb_scaled;
                    pix_valid <= 1'b1;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (idx == LAST) begin
                            state <= DRAIN;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= FETCH;
                        end
                    end
                end
                DRAIN: begin
                    if (!ser_busy) begin
                        cnt   <= '0;
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    if (cnt == TERM) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_pixel_feeder.sv
// Self-checking bench for ws2812_pixel_feeder: random frames checked
// against a frame-level model of ordering, scaling and latch timing.
module tb_ws2812_pixel_feeder;

    localparam int N     = 8;
    localparam int TICKS = 1620;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [23:0] wr_rgb;
    logic [7:0]  brightness;
    logic        frame_go;
    logic [23:0] pix_color;
    logic        pix_valid;
    logic        pix_ready;
    logic        ser_busy;
    logic        busy;
    logic        frame_done;

    int vectors = 0;
    int errors  = 0;

    logic [23:0] mdl [N];
    logic [23:0] obs [N];
    int          got;

    always #5 clk = ~clk;

    ws2812_pixel_feeder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_rgb     (wr_rgb),
        .brightness (brightness),
        .frame_go   (frame_go),
        .pix_color  (pix_color),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .ser_busy   (ser_busy),
        .busy       (busy),
        .frame_done (frame_done)
    );

    function automatic logic [23:0] ref_pix(input logic [23:0] rgb,
                                            input int b);
        int r, g, bl;
        r  = int'(rgb[23:16]) * (b + 1) / 256;
        g  = int'(rgb[15:8]) * (b + 1) / 256;
        bl = int'(rgb[7:0]) * (b + 1) / 256;
        return {8'(g), 8'(r), 8'(bl)};
    endfunction

    task automatic write_px(input int a, input logic [23:0] v);
        wr_en   = 1'b1;
        wr_addr = 8'(a);
        wr_rgb  = v;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (a < N) mdl[a] = v;
    endtask

    // One full frame: stream, drain with ser_busy held, then latch gap.
    task automatic run_frame(input int bright, input int ready_pct,
                             input int hold);
        logic [23:0] exp_q [$];
        logic [23:0] held;
        bit          have_hold;
        int          first_v, last_t, n;
        for (int i = 0; i < N; i++)
            exp_q.push_back(ref_pix(mdl[i], bright));
        got = 0; first_v = -1; last_t = -1; have_hold = 0;
        ser_busy   = 1'b1;
        brightness = 8'(bright);
        frame_go   = 1'b1;
        @(posedge clk); #1;
        frame_go = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: got %b want 1", busy);
        end
        for (int k = 0; k < 400 && got < N; k++) begin
            pix_ready  = ($urandom_range(99) < ready_pct);
            brightness = 8'($urandom);
            frame_go   = ($urandom_range(3) == 0);
            @(negedge clk);
            if (pix_valid === 1'b1 && first_v < 0) begin
                first_v = k;
                vectors++;
                if (k != 1) begin
                    errors++;
                    $display("FAIL latency: got %0d want 1", k);
                end
            end
            if (have_hold) begin
                vectors++;
                if (pix_valid !== 1'b1 || pix_color !== held) begin
                    errors++;
                    $display("FAIL stable: got %b/%h want 1/%h",
                             pix_valid, pix_color, held);
                end
            end
            vectors++;
            if (frame_done !== 1'b0) begin
                errors++;
                $display("FAIL early_done: got %b want 0", frame_done);
            end
            have_hold = 0;
            if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
                obs[got] = pix_color;
                vectors++;
                if (pix_color !== exp_q[got]) begin
                    errors++;
                    $display("FAIL pixel%0d: got %h want %h",
                             got, pix_color, exp_q[got]);
                end
                got++;
                last_t = k;
            end else if (pix_valid === 1'b1) begin
                held      = pix_color;
                have_hold = 1;
            end
            @(posedge clk); #1;
        end
        frame_go  = 1'b0;
        pix_ready = 1'b0;
        vectors++;
        if (got != N) begin
            errors++;
            $display("FAIL xfer_count: got %0d want %0d", got, N);
        end
        if (ready_pct >= 100) begin
            vectors++;
            if (last_t != 2 * N - 1) begin
                errors++;
                $display("FAIL pacing: got %0d want %0d", last_t, 2*N-1);
            end
        end
        repeat (hold) begin
            frame_go = ($urandom_range(3) == 0);
            @(posedge clk); #1;
            vectors++;
            if (pix_valid !== 0 || frame_done !== 0 || busy !== 1) begin
                errors++;
                $display("FAIL drain: got v%b d%b b%b want v0 d0 b1",
                         pix_valid, frame_done, busy);
            end
        end
        frame_go = 1'b0;
        ser_busy = 1'b0;
        n = 0;
        // ser_busy is seen low at the first edge; the pulse follows
        // TICKS edges after that one.
        do begin
            @(posedge clk); n++; #1;
        end while (frame_done !== 1'b1 && n < TICKS + 20);
        vectors++;
        if (n != TICKS + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL latch: got %0d busy %b want %0d busy 0",
                     n, busy, TICKS + 1);
        end
        repeat (3) begin
            @(posedge clk); #1;
            vectors++;
            if (frame_done !== 0 || busy !== 0) begin
                errors++;
                $display("FAIL after_done: got d%b b%b want d0 b0",
                         frame_done, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        frame_go = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            vectors++;
            if (pix_valid !== 0 || busy !== 0 || frame_done !== 0) begin
                errors++;
                $display("FAIL reset: got v%b b%b d%b want 0 0 0",
                         pix_valid, busy, frame_done);
            end
        end
        rst_n    = 1'b1;
        frame_go = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            vectors++;
            if (pix_valid !== 0 || busy !== 0) begin
                errors++;
                $display("FAIL idle: got v%b b%b want 0 0",
                         pix_valid, busy);
            end
        end
    endtask

    task automatic test_ordering();
        for (int i = 0; i < N; i++) write_px(i, 24'($urandom));
        write_px(0, 24'h102030);
        write_px(1, 24'hFF0080);
        run_frame(255, 100, 0);
        vectors++;
        if (obs[0] !== 24'h201030 || obs[1] !== 24'h00FF80) begin
            errors++;
            $display("FAIL order: got %h %h want 201030 00ff80",
                     obs[0], obs[1]);
        end
    endtask

    task automatic test_brightness();
        write_px(0, 24'hFF8001);
        run_frame(127, 100, 0);
        vectors++;
        if (obs[0] !== 24'h407F00) begin
            errors++;
            $display("FAIL bright127: got %h want 407f00", obs[0]);
        end
        run_frame(0, 100, 0);
        vectors++;
        if (obs[0] !== 24'h000000) begin
            errors++;
            $display("FAIL bright0: got %h want 000000", obs[0]);
        end
    endtask

    task automatic test_backpressure();
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) write_px(i, 24'($urandom));
            run_frame(int'($urandom_range(255)),
                      int'($urandom_range(70, 30)),
                      int'($urandom_range(20)));
        end
    endtask

    task automatic test_latch();
        run_frame(200, 60, 100);
    endtask

    task automatic test_abuse();
        bit seen;
        write_px(0, 24'h123456);
        write_px(N, 24'hABCDEF);
        run_frame(255, 100, 0);
        vectors++;
        if (obs[0] !== 24'h341256) begin
            errors++;
            $display("FAIL bad_addr: got %h want 341256", obs[0]);
        end
        ser_busy  = 1'b1;
        pix_ready = 1'b0;
        frame_go  = 1'b1;
        @(posedge clk); #1;
        frame_go = 1'b0;
        for (int k = 0; k < 10 && pix_valid !== 1'b1; k++) begin
            @(posedge clk); #1;
        end
        vectors++;
        if (pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL present_wait: got %b want 1", pix_valid);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (pix_valid !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL mid_reset: got v%b b%b want 0 0",
                     pix_valid, busy);
        end
        rst_n    = 1'b1;
        ser_busy = 1'b0;
        seen     = 0;
        repeat (TICKS + 50) begin
            @(posedge clk); #1;
            if (frame_done !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        vectors++;
        if (seen) begin
            errors++;
            $display("FAIL abort_done: got pulse/busy want none");
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_rgb     = '0;
        brightness = '0;
        frame_go   = 1'b0;
        pix_ready  = 1'b0;
        ser_busy   = 1'b0;
        test_reset();
        test_ordering();
        test_brightness();
        test_backpressure();
        test_latch();
        test_abuse();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
